// File: rtl/uart_rx_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_stream
// Purpose  : 8N1 UART receiver with FWFT byte FIFO, valid/ready output,
//            rts flow control and frame-error / overrun pulses.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_stream #(
    parameter int BIT_CLK    = 87,
    parameter int DEPTH      = 16,
    parameter int RTS_MARGIN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       rts,
    output logic [7:0] rxdata,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int C_HALF = BIT_CLK / 2;
    localparam int C_CW   = $clog2(BIT_CLK);
    localparam int C_AW   = $clog2(DEPTH);
    localparam int C_NW   = C_AW + 1;

    localparam logic [C_CW-1:0] C_CNT_HALF = C_CW'(C_HALF - 1);
    localparam logic [C_CW-1:0] C_CNT_LAST = C_CW'(BIT_CLK - 1);
    localparam logic [C_NW-1:0] C_FULL     = C_NW'(DEPTH);
    localparam logic [C_NW-1:0] C_RTS_MAX  = C_NW'(DEPTH - RTS_MARGIN - 1);

    localparam logic [2:0] C_ST_IDLE  = 3'd0;
    localparam logic [2:0] C_ST_START = 3'd1;
    localparam logic [2:0] C_ST_DATA  = 3'd2;
    localparam logic [2:0] C_ST_STOP  = 3'd3;
    localparam logic [2:0] C_ST_WAIT  = 3'd4;

    logic            sync1_q, rxs_q;
    logic [2:0]      state_q, state_d;
    logic [C_CW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [C_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [C_NW-1:0] count_q, count_d;
    logic            rts_q, rts_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;

    logic            stop_tick, push_req, push_ok, pop, full;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= C_ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rts_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rxd;
            rxs_q       <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rts_q       <= rts_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + C_CW'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        case (state_q)
            C_ST_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = C_ST_START;
            end
            C_ST_START: begin
                if (cnt_q == C_CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs_q ? C_ST_IDLE : C_ST_DATA;
                end
            end
            C_ST_DATA: begin
                if (cnt_q == C_CNT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rxs_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = C_ST_STOP;
                end
            end
            C_ST_STOP: begin
                if (cnt_q == C_CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = rxs_q ? C_ST_IDLE : C_ST_WAIT;
                end
            end
            C_ST_WAIT: begin
                cnt_d = '0;
                if (rxs_q) state_d = C_ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = C_ST_IDLE;
            end
        endcase
    end

    // When full, a same-cycle pop frees the slot the push lands in (wr_ptr == rd_ptr).
    always_comb begin
        stop_tick   = (state_q == C_ST_STOP) && (cnt_q == C_CNT_LAST);
        push_req    = stop_tick && rxs_q;
        frame_err_d = stop_tick && !rxs_q;
        pop         = (count_q != '0) && rx_ready;
        full        = (count_q == C_FULL);
        push_ok     = push_req && (!full || pop);
        overrun_d   = push_req && full && !pop;

        mem_d = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = shreg_q;
        wr_ptr_d = wr_ptr_q + C_AW'(push_ok);
        rd_ptr_d = rd_ptr_q + C_AW'(pop);
        count_d  = count_q + C_NW'(push_ok) - C_NW'(pop);
        rts_d    = (count_d <= C_RTS_MAX);
    end

    assign rxdata    = mem_q[rd_ptr_q];
    assign rx_valid  = (count_q != '0);
    assign rts       = rts_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_stream
// Purpose  : Self-checking bench for uart_rx_stream (scoreboard + vector table).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_stream;

    localparam int BIT_CLK    = 87;
    localparam int DEPTH      = 16;
    localparam int RTS_MARGIN = 4;
    localparam int C_HALF     = BIT_CLK / 2;
    // Input drive to stop-sample edge: 3 edges of sync + IDLE detection, then HALF + 9 bits.
    localparam int C_T_STOP   = 3 + C_HALF + 9 * BIT_CLK;
    localparam int C_RTS_MAX  = DEPTH - RTS_MARGIN - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic       rts;
    logic [7:0] rxdata;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int   checks   = 0;
    int   failures = 0;
    int   ferr_cnt = 0;
    int   ovr_cnt  = 0;
    bit   done;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_push;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    uart_rx_stream #(
        .BIT_CLK   (BIT_CLK),
        .DEPTH     (DEPTH),
        .RTS_MARGIN(RTS_MARGIN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .rts      (rts),
        .rxdata   (rxdata),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        tick(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(BIT_CLK);
        end
        rxd = stop_bit;
        tick(BIT_CLK);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    // Scoreboard: every accepted handshake must return the oldest expected byte.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err === 1'b1) ferr_cnt++;
            if (overrun === 1'b1) ovr_cnt++;
            if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_data unexpected byte actual=%0h required=none at %0t", rxdata, $time);
                end else begin
                    chk("rx_data", {24'd0, rxdata}, {24'd0, sb.pop_front()});
                end
            end
        end
    end

    initial begin
        int f0, o0, model_cnt;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 0};
        vecs[4] = '{8'h5A, 1'b0, 1'b0, 1};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 0};

        reset = 1'b1; rxd = 1'b1; rx_ready = 1'b0; done = 1'b0;
        tick(3);
        chk("reset_rts", {31'd0, rts}, 0);
        chk("reset_valid", {31'd0, rx_valid}, 0);
        chk("reset_rxdata", {24'd0, rxdata}, 0);
        chk("reset_frame_err", {31'd0, frame_err}, 0);
        chk("reset_overrun", {31'd0, overrun}, 0);
        reset = 1'b0;
        tick(1);
        chk("rts_after_reset", {31'd0, rts}, 1);
        tick(2);

        // Single byte with exact latency
        f0 = ferr_cnt;
        sb.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                tick(C_T_STOP - 1);
                chk("valid_before_stop", {31'd0, rx_valid}, 0);
                tick(1);
                chk("valid_after_stop", {31'd0, rx_valid}, 1);
                chk("rxdata_head", {24'd0, rxdata}, 32'hA5);
            end
        join
        pop_one();
        chk("valid_after_pop", {31'd0, rx_valid}, 0);
        chk("single_no_ferr", ferr_cnt - f0, 0);

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            if (vecs[v].exp_push) sb.push_back(vecs[v].data);
            send_frame(vecs[v].data, vecs[v].stop_bit);
            rxd = 1'b1;
            tick(BIT_CLK);
            chk($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
            chk($sformatf("vec%0d_valid", v), {31'd0, rx_valid}, {31'd0, vecs[v].exp_push});
            pop_one();
            tick(1);
            chk($sformatf("vec%0d_drained", v), {31'd0, rx_valid}, 0);
            chk($sformatf("vec%0d_ovr", v), ovr_cnt - o0, 0);
        end

        // False start
        f0 = ferr_cnt;
        rxd = 1'b0;
        tick(20);
        rxd = 1'b1;
        tick(2 * BIT_CLK);
        chk("false_start_valid", {31'd0, rx_valid}, 0);
        chk("false_start_ferr", ferr_cnt - f0, 0);

        // Framing error followed by a long break: exactly one pulse
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        tick(12 * BIT_CLK);
        rxd = 1'b1;
        tick(BIT_CLK);
        chk("break_ferr_once", ferr_cnt - f0, 1);
        chk("break_no_push", {31'd0, rx_valid}, 0);

        // Flow control and overrun: 17 back-to-back bytes, no reads
        o0 = ovr_cnt;
        for (int k = 0; k < 17; k++) begin
            if (k < DEPTH) sb.push_back(8'(k));
            fork
                send_frame(8'(k), 1'b1);
                begin
                    if (k == 11) begin
                        tick(C_T_STOP - 1);
                        chk("rts_before_12th", {31'd0, rts}, 1);
                        tick(1);
                        chk("rts_after_12th", {31'd0, rts}, 0);
                    end
                end
            join
        end
        chk("overrun_once", ovr_cnt - o0, 1);
        chk("full_valid", {31'd0, rx_valid}, 1);

        // Full with simultaneous pop: 0x00 leaves, 0x30 enters, no overrun
        sb.push_back(8'h30);
        fork
            send_frame(8'h30, 1'b1);
            begin
                tick(C_T_STOP - 1);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
                chk("full_pop_rts_low", {31'd0, rts}, 0);
            end
        join
        chk("full_pop_no_overrun", ovr_cnt - o0, 1);

        model_cnt = DEPTH;
        for (int j = 0; j < DEPTH; j++) begin
            pop_one();
            model_cnt--;
            chk($sformatf("drain_rts_%0d", j), {31'd0, rts}, {31'd0, (model_cnt <= C_RTS_MAX)});
            tick(1);
        end
        chk("drain_empty", {31'd0, rx_valid}, 0);

        // Reset during data bit 4 of 0xFF
        fork
            send_frame(8'hFF, 1'b1);
            begin
                tick(3 + C_HALF + 4 * BIT_CLK + BIT_CLK / 2);
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
                chk("midrst_rts", {31'd0, rts}, 0);
                chk("midrst_valid", {31'd0, rx_valid}, 0);
                chk("midrst_rxdata", {24'd0, rxdata}, 0);
                chk("midrst_pulses", {30'd0, frame_err, overrun}, 0);
                tick(1);
                chk("midrst_rts_rise", {31'd0, rts}, 1);
            end
        join
        rxd = 1'b1;
        tick(BIT_CLK);
        chk("midrst_no_push", {31'd0, rx_valid}, 0);
        sb.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        tick(BIT_CLK);
        chk("after_rst_valid", {31'd0, rx_valid}, 1);
        pop_one();
        chk("after_rst_drained", {31'd0, rx_valid}, 0);

        // Pointer wrap: 40 streamed bytes, random ready
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    sb.push_back(8'(i * 7 + 3));
                    send_frame(8'(i * 7 + 3), 1'b1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rx_ready = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
        join
        rx_ready = 1'b1;
        tick(4);
        rx_ready = 1'b0;
        tick(1);
        chk("wrap_empty", {31'd0, rx_valid}, 0);
        chk("wrap_no_ovr", ovr_cnt - o0, 0);
        chk("wrap_no_ferr", ferr_cnt - f0, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
